// File: rtl/mem_responder.sv
// mem_responder: word-addressed memory model answering one request at a time
// after a fixed, programmable latency. Storage is a register array that is
// cleared by reset.
module mem_responder #(
   parameter int unsigned ADDR_W  = 5,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned LATENCY = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req,
   input  logic              wr,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data,
   output logic              ready,
   output logic              ack,
   output logic [DATA_W-1:0] q
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t              r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_wr;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_data;
   logic [DATA_W-1:0]   r_mem [DEPTH];

   // Request sequencing, memory access and registered handshake outputs.
   // A request held across the RESP exit edge is taken as the next
   // acceptance, giving one request per LATENCY+1 cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_wr    <= 1'b0;
         r_addr  <= '0;
         r_data  <= '0;
         r_mem   <= '{default: '0};
         ready   <= 1'b1;
         ack     <= 1'b0;
         q       <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req) begin
                  r_wr    <= wr;
                  r_addr  <= addr;
                  r_data  <= data;
                  r_cnt   <= CNT_W'(LATENCY - 1);
                  ready   <= 1'b0;
                  r_state <= S_BUSY;
               end
            end
            S_BUSY: begin
               if (r_cnt == '0) begin
                  if (r_wr) begin
                     r_mem[r_addr] <= r_data;
                  end else begin
                     q <= r_mem[r_addr];
                  end
                  ack     <= 1'b1;
                  r_state <= S_RESP;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            S_RESP: begin
               ack <= 1'b0;
               if (req) begin
                  r_wr    <= wr;
                  r_addr  <= addr;
                  r_data  <= data;
                  r_cnt   <= CNT_W'(LATENCY - 1);
                  r_state <= S_BUSY;
               end else begin
                  ready   <= 1'b1;
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
               ready   <= 1'b1;
               ack     <= 1'b0;
            end
         endcase
      end
   end

endmodule
